// File: rtl/oh_cdc_pkg.sv
// Shared CDC helpers: counter-width and latency constant functions for the
// synchronizer/filter family.
package oh_cdc_pkg;

  function automatic int cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

  function automatic int blank_width(input int ps);
    return (ps < 1) ? 1 : $clog2(ps + 1);
  endfunction

  // Edges from the first sampling edge of a stable new level to the dout change.
  function automatic int FILTER_LAT(input int ps, input int hold);
    return ps + hold;
  endfunction

endpackage

// File: rtl/oh_dsync.sv
// Multi-stage control-signal synchronizer, DW independent lanes, PS flops deep.
module oh_dsync #(
  parameter int DW = 1,
  parameter int PS = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] sync_q [PS];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < PS; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < PS; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign dout = sync_q[PS-1];

endmodule

// File: rtl/oh_dsync_filter.sv
// Synchronizer plus per-lane debounce: accepts a level after HOLD stable cycles
// and pulses rise/fall. Optional sticky glitch flags under OH_DSYNC_FILTER_GLITCH_EN.
module oh_dsync_filter
  import oh_cdc_pkg::*;
#(
  parameter int            PS        = 2,
  parameter int            DW        = 1,
  parameter int            HOLD      = 4,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  output logic [DW-1:0] glitch
);

  localparam int CW = cnt_width(HOLD);
  localparam int BW = blank_width(PS);
  localparam logic [BW-1:0] BLANK_END = BW'(PS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD - 1);

  logic [DW-1:0] s;
  logic [BW-1:0] blank_q;
  logic          blanking;

  oh_dsync #(
    .DW (DW),
    .PS (PS)
  ) u_dsync (
    .clk    (clk),
    .nreset (nreset),
    .din    (din),
    .dout   (s)
  );

  // Synchronizer contents are not trusted until PS edges after reset release.
  assign blanking = (blank_q != BLANK_END);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) blank_q <= '0;
    else if (blanking) blank_q <= blank_q + BW'(1);
  end

  for (genvar i = 0; i < DW; i++) begin : g_lane
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
      cnt_d  = '0;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (!blanking && (s[i] != dout_q)) begin
        if (cnt_q == CNT_LAST) begin
          dout_d = s[i];
          rise_d = s[i];
          fall_d = ~s[i];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        cnt_q  <= '0;
        dout_q <= RESET_VAL[i];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign dout[i] = dout_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;

`ifdef OH_DSYNC_FILTER_GLITCH_EN
    logic glitch_q;
    logic glitch_set;

    // An aborted qualification run: the input fell back before being accepted.
    assign glitch_set = !blanking && (cnt_q != '0) && (s[i] == dout_q);

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) glitch_q <= 1'b0;
      else glitch_q <= glitch_set | (glitch_q & ~clr);
    end

    assign glitch[i] = glitch_q;
`else
    assign glitch[i] = 1'b0;
`endif
  end

`ifndef OH_DSYNC_FILTER_GLITCH_EN
  logic unused_clr;
  assign unused_clr = clr;
`endif

endmodule

// File: tb/tb_oh_dsync_filter.sv
// Directed bench for oh_dsync_filter: PS=2/HOLD=4/DW=2 main instance plus a
// PS=2/HOLD=1/DW=1 instance for the degenerate case.
module tb_oh_dsync_filter;

  localparam int PS   = 2;
  localparam int HOLD = 4;
  localparam int LAT  = PS + HOLD;

  logic       clk;
  logic       nreset;
  logic [1:0] din;
  logic       clr;
  logic [1:0] dout, rise, fall, glitch;

  logic       din_s;
  logic       dout_s, rise_s, fall_s, glitch_s;

  int checks   = 0;
  int failures = 0;

`ifdef OH_DSYNC_FILTER_GLITCH_EN
  localparam logic [1:0] EXP_GLITCH0 = 2'b01;
`else
  localparam logic [1:0] EXP_GLITCH0 = 2'b00;
`endif

  oh_dsync_filter #(
    .PS        (PS),
    .DW        (2),
    .HOLD      (HOLD),
    .RESET_VAL (2'b00)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .din    (din),
    .clr    (clr),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .glitch (glitch)
  );

  oh_dsync_filter #(
    .PS        (2),
    .DW        (1),
    .HOLD      (1),
    .RESET_VAL (1'b0)
  ) dut_h1 (
    .clk    (clk),
    .nreset (nreset),
    .din    (din_s),
    .clr    (clr),
    .dout   (dout_s),
    .rise   (rise_s),
    .fall   (fall_s),
    .glitch (glitch_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then land on the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input logic [1:0] v);
    din = v;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    din    = 2'b11;
    din_s  = 1'b0;
    clr    = 1'b0;
    repeat (4) tick();
    if ({dout, rise, fall, glitch} !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold: dout/rise/fall/glitch=%b required 00000000", {dout, rise, fall, glitch});
    end
    checks++;
    if ({dout_s, rise_s, fall_s} !== 3'b000) begin
      failures++;
      $display("FAIL reset_hold_h1: dout/rise/fall=%b required 000", {dout_s, rise_s, fall_s});
    end
    checks++;
    nreset = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (dout !== ((k >= LAT) ? 2'b11 : 2'b00)) begin
        failures++;
        $display("FAIL reset_dout edge %0d: got %b required %b", k, dout, (k >= LAT) ? 2'b11 : 2'b00);
      end
      checks++;
      if (rise !== ((k == LAT) ? 2'b11 : 2'b00) || fall !== 2'b00) begin
        failures++;
        $display("FAIL reset_pulse edge %0d: rise=%b fall=%b required rise=%b fall=00",
                 k, rise, fall, (k == LAT) ? 2'b11 : 2'b00);
      end
      checks++;
    end
  endtask

  task automatic test_lane0_rise();
    settle(2'b00);
    din = 2'b01;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (dout !== ((k >= LAT) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL lane0_dout edge %0d: got %b required %b", k, dout, (k >= LAT) ? 2'b01 : 2'b00);
      end
      checks++;
      if (rise !== ((k == LAT) ? 2'b01 : 2'b00) || fall !== 2'b00) begin
        failures++;
        $display("FAIL lane0_pulse edge %0d: rise=%b fall=%b required rise=%b fall=00",
                 k, rise, fall, (k == LAT) ? 2'b01 : 2'b00);
      end
      checks++;
    end
  endtask

  task automatic test_glitch();
    settle(2'b00);
    din = 2'b01;
    repeat (3) tick();
    din = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (dout !== 2'b00 || rise !== 2'b00) begin
        failures++;
        $display("FAIL glitch_no_accept edge %0d: dout=%b rise=%b required 00/00", k + 3, dout, rise);
      end
      checks++;
    end
    if (glitch !== EXP_GLITCH0) begin
      failures++;
      $display("FAIL glitch_flag: got %b required %b", glitch, EXP_GLITCH0);
    end
    checks++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    if (glitch !== 2'b00) begin
      failures++;
      $display("FAIL glitch_clr: got %b required 00", glitch);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    settle(2'b10);
    din = 2'b01;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (dout !== ((k == LAT) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL simul_dout edge %0d: got %b required %b", k, dout, (k == LAT) ? 2'b01 : 2'b10);
      end
      checks++;
    end
    if (rise !== 2'b01 || fall !== 2'b10) begin
      failures++;
      $display("FAIL simul_pulse: rise=%b fall=%b required rise=01 fall=10", rise, fall);
    end
    checks++;
    tick();
    if (rise !== 2'b00 || fall !== 2'b00) begin
      failures++;
      $display("FAIL simul_pulse_end: rise=%b fall=%b required 00/00", rise, fall);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    settle(2'b00);
    din = 2'b01;
    repeat (4) tick();
    nreset = 1'b0;
    #1;
    if (dout !== 2'b00 || rise !== 2'b00) begin
      failures++;
      $display("FAIL midreset_immediate: dout=%b rise=%b required 00/00", dout, rise);
    end
    checks++;
    @(negedge clk);
    tick();
    nreset = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (dout !== ((k == LAT) ? 2'b01 : 2'b00) || rise !== ((k == LAT) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL midreset_requal edge %0d: dout=%b rise=%b required %b/%b",
                 k, dout, rise, (k == LAT) ? 2'b01 : 2'b00, (k == LAT) ? 2'b01 : 2'b00);
      end
      checks++;
    end
  endtask

  task automatic test_hold1();
    din_s = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (dout_s !== (k >= 3) || rise_s !== (k == 3) || fall_s !== 1'b0) begin
        failures++;
        $display("FAIL hold1_rise edge %0d: dout=%b rise=%b fall=%b required %b/%b/0",
                 k, dout_s, rise_s, fall_s, k >= 3, k == 3);
      end
      checks++;
    end
    din_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (dout_s !== (k < 3) || fall_s !== (k == 3) || rise_s !== 1'b0) begin
        failures++;
        $display("FAIL hold1_fall edge %0d: dout=%b fall=%b rise=%b required %b/%b/0",
                 k, dout_s, fall_s, rise_s, k < 3, k == 3);
      end
      checks++;
    end
    if (glitch_s !== 1'b0) begin
      failures++;
      $display("FAIL hold1_glitch: got %b required 0", glitch_s);
    end
    checks++;
  endtask

  initial begin
    nreset = 1'b0;
    din    = 2'b00;
    din_s  = 1'b0;
    clr    = 1'b0;
    test_reset();
    test_lane0_rise();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
